// File: rtl/fsmc_pkg.sv
// rtl/fsmc_pkg.sv - shared types and constants for the FSMC register bridge
// Contents:
//   fsmc_state_t        bridge FSM states
//   FSMC_DEF_BASE_ADDR  default address of register 0
//   FSMC_ERR_CNT_W      width of the optional error counter
package fsmc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } fsmc_state_t;

    localparam logic [17:0] FSMC_DEF_BASE_ADDR = 18'h100;
    localparam int          FSMC_ERR_CNT_W     = 8;

endpackage

// File: rtl/fsmc_sync.sv
// rtl/fsmc_sync.sv - 2-FF synchroniser with rise/fall detection on the synced value
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset; all stages load RST_VAL
//   i_d      asynchronous input, W bits
//   o_q      synchronised value
//   o_rise   per-bit 0->1 transition seen on o_q this cycle
//   o_fall   per-bit 1->0 transition seen on o_q this cycle
module fsmc_sync #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q,
    output logic [W-1:0] o_rise,
    output logic [W-1:0] o_fall
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;
    logic [W-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_q    = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/fsmc_reg_bridge.sv
// rtl/fsmc_reg_bridge.sv - MCU FSMC multiplexed-bus to register-bank bridge
// Optional feature: define FSMC_ERR_CNT_EN for an 8-bit saturating error counter
// at BASE_ADDR+NUM_REGS (read returns count, write clears).
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   NADV     address-valid strobe, active low, asynchronous
//   NWE      write strobe, active low, asynchronous
//   NOE      read strobe, active low, asynchronous
//   AD       multiplexed address/data bus, high-Z unless reading
//   reg_q    flattened register bank, register i at [i*DATA_W +: DATA_W]
//   wr_stb   one-cycle pulse per register write
//   wr_idx   index of the written register, valid with wr_stb
//   busy     FSM not in IDLE
module fsmc_reg_bridge
    import fsmc_pkg::*;
#(
    parameter int                AD_W      = 18,
    parameter int                DATA_W    = 16,
    parameter int                NUM_REGS  = 8,
    parameter logic [AD_W-1:0]   BASE_ADDR = AD_W'(FSMC_DEF_BASE_ADDR),
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         NADV,
    input  logic                         NWE,
    input  logic                         NOE,
    inout  wire  [AD_W-1:0]              AD,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic                         wr_stb,
    output logic [$clog2(NUM_REGS)-1:0]  wr_idx,
    output logic                         busy
);

    localparam int              IDX_W      = $clog2(NUM_REGS);
    localparam logic [AD_W-1:0] NUM_REGS_A = AD_W'(NUM_REGS);

    fsmc_state_t r_state;
    fsmc_state_t w_state_nxt;

    logic [AD_W-1:0]   r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              r_oe;
    logic              r_wr_stb;
    logic [IDX_W-1:0]  r_wr_idx;

    // Strobe bit order: [2]=NADV, [1]=NWE, [0]=NOE
    logic [2:0]        w_strb_q;
    logic [2:0]        w_strb_rise;
    logic [2:0]        w_strb_fall;
    logic [AD_W-1:0]   w_ad_q;
    logic [AD_W-1:0]   w_ad_rise;
    logic [AD_W-1:0]   w_ad_fall;

    logic              w_nadv_q;
    logic              w_nwe_q;
    logic              w_noe_q;
    logic              w_nadv_rise;
    logic              w_nadv_fall;
    logic              w_nwe_rise;
    logic              w_noe_rise;

    logic              w_cap_addr;
    logic              w_cap_wdata;
    logic              w_commit;
    logic              w_abort;

    logic [AD_W-1:0]   w_offset;
    logic              w_hit_reg;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused;

    fsmc_sync #(.W(3)) u_sync_strb (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     ({NADV, NWE, NOE}),
        .o_q     (w_strb_q),
        .o_rise  (w_strb_rise),
        .o_fall  (w_strb_fall)
    );

    fsmc_sync #(.W(AD_W)) u_sync_ad (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (AD),
        .o_q     (w_ad_q),
        .o_rise  (w_ad_rise),
        .o_fall  (w_ad_fall)
    );

    assign w_nadv_q    = w_strb_q[2];
    assign w_nwe_q     = w_strb_q[1];
    assign w_noe_q     = w_strb_q[0];
    assign w_nadv_rise = w_strb_rise[2];
    assign w_nwe_rise  = w_strb_rise[1];
    assign w_noe_rise  = w_strb_rise[0];
    assign w_nadv_fall = w_strb_fall[2];
    assign w_unused    = ^{w_strb_fall[1:0], w_ad_rise, w_ad_fall};

    // Address decode; the subtraction wraps for addresses below BASE_ADDR,
    // so the lower-bound compare is kept explicit.
    assign w_offset  = r_addr - BASE_ADDR;
    assign w_hit_reg = (r_addr >= BASE_ADDR) && (w_offset < NUM_REGS_A);
    assign w_idx     = w_offset[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An NADV fall always wins: the MCU has started a new access, so the
    // current one is dropped even if a strobe rise arrives in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cap_addr  = 1'b0;
        w_cap_wdata = 1'b0;
        w_commit    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_nadv_q) w_state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                // On the rise cycle the previous capture is kept, since the
                // bus may already be turning to data.
                if (w_nadv_rise) w_state_nxt = ST_WAIT;
                else             w_cap_addr  = 1'b1;
            end
            ST_WAIT: begin
                if (w_nadv_fall) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_ADDR;
                end else if (!w_nwe_q && !w_noe_q) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (!w_nwe_q) begin
                    w_state_nxt = ST_WRITE;
                end else if (!w_noe_q) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_WRITE: begin
                if (w_nadv_fall) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_ADDR;
                end else if (!w_nwe_q && !w_noe_q) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_nwe_rise) begin
                    // r_wdata still holds the sample from the cycle before the rise
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cap_wdata = 1'b1;
                end
            end
            ST_READ: begin
                if (w_nadv_fall) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_ADDR;
                end else if (!w_nwe_q && !w_noe_q) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_noe_rise) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_oe     <= 1'b0;
            r_wr_stb <= 1'b0;
            r_wr_idx <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
        end else begin
            // Registered enable: drive starts the cycle after READ entry and
            // persists one cycle past the exit on NOE rise.
            r_oe     <= (r_state == ST_READ) && !w_abort;
            r_wr_stb <= w_commit && w_hit_reg;
            if (w_cap_addr)  r_addr  <= w_ad_q;
            if (w_cap_wdata) r_wdata <= w_ad_q[DATA_W-1:0];
            if (w_commit && w_hit_reg) begin
                r_regs[w_idx] <= r_wdata;
                r_wr_idx      <= w_idx;
            end
        end
    end

`ifdef FSMC_ERR_CNT_EN
    logic [FSMC_ERR_CNT_W-1:0] r_err_cnt;
    logic                      w_hit_cnt;
    logic                      w_rd_entry;
    logic                      w_err_evt;

    assign w_hit_cnt  = (r_addr >= BASE_ADDR) && (w_offset == NUM_REGS_A);
    assign w_rd_entry = (r_state == ST_WAIT) && (w_state_nxt == ST_READ);
    assign w_err_evt  = w_abort ||
                        ((w_commit || w_rd_entry) && !w_hit_reg && !w_hit_cnt);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_err_cnt <= '0;
        end else if (w_commit && w_hit_cnt) begin
            r_err_cnt <= '0;
        end else if (w_err_evt && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign w_rdata = w_hit_reg ? r_regs[w_idx] :
                     w_hit_cnt ? DATA_W'(r_err_cnt) : '0;
`else
    assign w_rdata = w_hit_reg ? r_regs[w_idx] : '0;
`endif

    assign AD = r_oe ? AD_W'(w_rdata) : {AD_W{1'bz}};

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) reg_q[i*DATA_W +: DATA_W] = r_regs[i];
    end

    assign wr_stb = r_wr_stb;
    assign wr_idx = r_wr_idx;
    assign busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fsmc_reg_bridge.sv
// tb/tb_fsmc_reg_bridge.sv - directed self-checking bench for fsmc_reg_bridge
module tb_fsmc_reg_bridge;

    localparam int AD_W     = 18;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam logic [AD_W-1:0] AD_HIZ = '1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic NADV    = 1'b1;
    logic NWE     = 1'b1;
    logic NOE     = 1'b1;
    logic [AD_W-1:0] tb_ad    = '0;
    logic            tb_ad_oe = 1'b0;
    wire  [AD_W-1:0] AD;

    logic [NUM_REGS*DATA_W-1:0] reg_q;
    logic                       wr_stb;
    logic [2:0]                 wr_idx;
    logic                       busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         stb_cnt  = 0;
    logic [2:0] last_idx = '0;

    // Released bus floats high; the bridge always drives AD[17:16]=0,
    // so AD == all-ones identifies a released bus.
    assign AD = tb_ad_oe ? tb_ad : {AD_W{1'bz}};
    pullup (AD);

    fsmc_reg_bridge dut (
        .clk     (clk),
        .reset_n (reset_n),
        .NADV    (NADV),
        .NWE     (NWE),
        .NOE     (NOE),
        .AD      (AD),
        .reg_q   (reg_q),
        .wr_stb  (wr_stb),
        .wr_idx  (wr_idx),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_stb) begin
            stb_cnt  = stb_cnt + 1;
            last_idx = wr_idx;
        end
    end

    task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic addr_phase(input logic [AD_W-1:0] a);
        tb_ad    = a;
        tb_ad_oe = 1'b1;
        NADV     = 1'b0;
        tick(3);
        NADV     = 1'b1;
        tick(3);
    endtask

    // Returns wr_stb sampled 3 clk after the physical NWE rise.
    task automatic write_data(input logic [15:0] d, output logic stb_at_3);
        tb_ad    = {2'b00, d};
        tb_ad_oe = 1'b1;
        NWE      = 1'b0;
        tick(4);
        NWE      = 1'b1;
        tick(3);
        stb_at_3 = wr_stb;
        tb_ad_oe = 1'b0;
        tick(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         s0;
        int         ad_drv;
        logic       seen;
        logic [127:0] exp_q;

        tick(3);
        chk_eq("rst_busy",   busy,   1'b0);
        chk_eq("rst_wr_stb", wr_stb, 1'b0);
        chk_eq("rst_wr_idx", wr_idx, 3'd0);
        chk_eq("rst_reg_q",  reg_q,  128'h0);
        chk_eq("rst_ad_hiz", AD,     AD_HIZ);
        reset_n = 1'b1;
        tick(2);

        // Write 0x0F0F to 0x100
        s0 = stb_cnt;
        addr_phase(18'h100);
        write_data(16'h0F0F, seen);
        exp_q = 128'h0F0F;
        chk_eq("wr0_latency", seen, 1'b1);
        chk_eq("wr0_reg_q",   reg_q, exp_q);
        chk_eq("wr0_stb_cnt", stb_cnt - s0, 1);
        chk_eq("wr0_idx",     last_idx, 3'd0);
        chk_eq("wr0_idle",    busy, 1'b0);

        // Read 0x100, NOE low for 8 clk
        addr_phase(18'h100);
        tb_ad_oe = 1'b0;
        tick(1);
        NOE = 1'b0;
        tick(8);
        chk_eq("rd0_drive", AD, 18'h00F0F);
        chk_eq("rd0_busy",  busy, 1'b1);
        NOE = 1'b1;
        tick(1);
        chk_eq("rd0_after_rise", AD, 18'h00F0F);
        tick(2);
        chk_eq("rd0_hold", AD, 18'h00F0F);
        tick(2);
        chk_eq("rd0_release", AD, AD_HIZ);
        chk_eq("rd0_idle",    busy, 1'b0);

        // Unmapped writes just above and just below the window
        s0 = stb_cnt;
        addr_phase(18'h108);
        write_data(16'hABCD, seen);
        chk_eq("wr108_reg_q", reg_q, exp_q);
        addr_phase(18'h0FF);
        write_data(16'h5A5A, seen);
        chk_eq("wr0ff_reg_q",   reg_q, exp_q);
        chk_eq("unmapped_stbs", stb_cnt - s0, 0);

        // Abort a write to 0x103 with NADV; the new address phase targets 0x103
        s0 = stb_cnt;
        addr_phase(18'h103);
        tb_ad = 18'h05555;
        NWE   = 1'b0;
        tick(4);
        chk_eq("ab_in_write", busy, 1'b1);
        tb_ad = 18'h00103;
        NADV  = 1'b0;
        NWE   = 1'b1;
        tick(3);
        NADV  = 1'b1;
        tick(3);
        chk_eq("ab_reg3",  reg_q[63:48], 16'h0000);
        chk_eq("ab_no_stb", stb_cnt - s0, 0);
        write_data(16'h1234, seen);
        exp_q[63:48] = 16'h1234;
        chk_eq("ab_rewrite_reg_q", reg_q, exp_q);
        chk_eq("ab_rewrite_stb",   stb_cnt - s0, 1);
        chk_eq("ab_rewrite_idx",   last_idx, 3'd3);

        // Highest mapped register
        s0 = stb_cnt;
        addr_phase(18'h107);
        write_data(16'hBEEF, seen);
        exp_q[127:112] = 16'hBEEF;
        chk_eq("wr107_reg_q", reg_q, exp_q);
        chk_eq("wr107_idx",   last_idx, 3'd7);
        chk_eq("wr107_stb",   stb_cnt - s0, 1);

        // Read of unmapped 0x108 drives zeros
        addr_phase(18'h108);
        tb_ad_oe = 1'b0;
        tick(1);
        NOE = 1'b0;
        tick(6);
        chk_eq("rd108_zero", AD, 18'h00000);
        NOE = 1'b1;
        tick(6);
        chk_eq("rd108_release", AD, AD_HIZ);

        // Reset in the middle of a read
        addr_phase(18'h100);
        tb_ad_oe = 1'b0;
        tick(1);
        NOE = 1'b0;
        tick(6);
        chk_eq("rst_rd_drive", AD, 18'h00F0F);
        reset_n = 1'b0;
        tick(1);
        chk_eq("rst_rd_hiz",   AD,    AD_HIZ);
        chk_eq("rst_rd_busy",  busy,  1'b0);
        chk_eq("rst_rd_reg_q", reg_q, 128'h0);
        reset_n = 1'b1;
        NOE     = 1'b1;
        tick(4);

        // NWE and NOE together after an address phase to 0x101
        addr_phase(18'h101);
        tb_ad_oe = 1'b0;
        tick(1);
        s0     = stb_cnt;
        ad_drv = 0;
        NWE    = 1'b0;
        NOE    = 1'b0;
        repeat (8) begin
            tick(1);
            if (AD !== AD_HIZ) ad_drv++;
        end
        chk_eq("both_ad_driven", ad_drv, 0);
        chk_eq("both_idle",      busy,   1'b0);
        NWE = 1'b1;
        NOE = 1'b1;
        tick(4);
        chk_eq("both_no_stb", stb_cnt - s0, 0);
        chk_eq("both_reg_q",  reg_q, 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
